// File: rtl/motor_ctrl_pkg.sv
// Shared types for the motor control slice: quadrature state/step encodings
// and the x4 transition decoder used by qei_counter.
package motor_ctrl_pkg;

    typedef enum logic [1:0] {
        QS_00 = 2'b00,
        QS_01 = 2'b01,
        QS_10 = 2'b10,
        QS_11 = 2'b11
    } qei_state_t;

    typedef enum {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL} qei_step_t;

    // State is {A,B}; forward sequence is 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
    function automatic qei_state_t qei_fwd_next(input qei_state_t s);
        qei_state_t n;
        n = QS_00;
        if (s == QS_00) n = QS_10;
        else if (s == QS_10) n = QS_11;
        else if (s == QS_11) n = QS_01;
        else n = QS_00;
        return n;
    endfunction

    function automatic qei_step_t qei_decode(input qei_state_t prev, input qei_state_t cur);
        qei_step_t step;
        step = STEP_NONE;
        if (prev == cur)
            step = STEP_NONE;
        else if ((prev ^ cur) == 2'b11)
            step = STEP_ILLEGAL;
        else if (cur == qei_fwd_next(prev))
            step = STEP_FWD;
        else
            step = STEP_REV;
        return step;
    endfunction

endpackage

// File: rtl/qei_input_filter.sv
// One encoder channel: 2-FF synchroniser followed by a run-length glitch filter.
// i_load forces the filtered level to the synced level (used during warm-up).
module qei_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    input  logic i_load,
    output logic o_synced,
    output logic o_level
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_run;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_run   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (i_load) begin
                r_level <= r_sync2;
                r_run   <= '0;
            end else if (r_sync2 == r_level) begin
                r_run <= '0;
            end else if (r_run == RUN_LAST) begin
                // FILTER_LEN consecutive differing cycles: accept the new level
                r_level <= r_sync2;
                r_run   <= '0;
            end else begin
                r_run <= r_run + 1'b1;
            end
        end
    end

    assign o_synced = r_sync2;
    assign o_level  = r_level;

endmodule

// File: rtl/qei_counter.sv
// x4 quadrature decoder: filtered A/B in, wrapping signed position count,
// direction, step strobe and a saturating illegal-transition counter out.
module qei_counter
    import motor_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int FILTER_LEN = 4,
    parameter int DIR_INVERT = 0,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_enc_a,
    input  logic                        i_enc_b,
    input  logic                        i_count_clr,
    output logic signed [CNT_WIDTH-1:0] o_rot_cnt,
    output logic                        o_dir,
    output logic                        o_step_pulse,
    output logic        [ERR_WIDTH-1:0] o_err_cnt,
    output logic                        o_err_flag
);

    localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

    logic w_sync_a, w_sync_b;
    logic w_filt_a, w_filt_b;
    logic w_warm;
    logic w_valid;
    logic w_illegal;
    logic w_fwd;
    qei_state_t w_sync_s;
    qei_state_t w_cur_s;
    qei_step_t  w_step;

    logic [1:0]           r_warm;
    qei_state_t           r_prev;
    logic [CNT_WIDTH-1:0] r_rot_cnt;
    logic                 r_dir;
    logic                 r_step_pulse;
    logic [ERR_WIDTH-1:0] r_err_cnt;
    logic                 r_err_flag;

    qei_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_pin    (i_enc_a),
        .i_load   (w_warm),
        .o_synced (w_sync_a),
        .o_level  (w_filt_a)
    );

    qei_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_pin    (i_enc_b),
        .i_load   (w_warm),
        .o_synced (w_sync_b),
        .o_level  (w_filt_b)
    );

    // Warm-up spans the first three edges after reset so pins held static
    // through reset reach the filter and prev state without a phantom step.
    assign w_warm    = (r_warm != 2'd3);
    assign w_sync_s  = qei_state_t'({w_sync_a, w_sync_b});
    assign w_cur_s   = qei_state_t'({w_filt_a, w_filt_b});
    assign w_step    = w_warm ? STEP_NONE : qei_decode(r_prev, w_cur_s);
    assign w_valid   = (w_step == STEP_FWD) || (w_step == STEP_REV);
    assign w_illegal = (w_step == STEP_ILLEGAL);
    assign w_fwd     = (w_step == STEP_FWD) ^ (DIR_INVERT != 0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_warm       <= 2'd0;
            r_prev       <= QS_00;
            r_rot_cnt    <= '0;
            r_dir        <= 1'b0;
            r_step_pulse <= 1'b0;
            r_err_cnt    <= '0;
            r_err_flag   <= 1'b0;
        end else begin
            if (w_warm)
                r_warm <= r_warm + 2'd1;
            r_prev       <= w_warm ? w_sync_s : w_cur_s;
            r_step_pulse <= w_valid;
            if (w_valid)
                r_dir <= w_fwd;
            // Clear wins over a same-cycle step or error; dir/prev/strobe still follow the step.
            if (i_count_clr) begin
                r_rot_cnt  <= '0;
                r_err_cnt  <= '0;
                r_err_flag <= 1'b0;
            end else begin
                if (w_valid)
                    r_rot_cnt <= w_fwd ? r_rot_cnt + 1'b1 : r_rot_cnt - 1'b1;
                if (w_illegal) begin
                    r_err_flag <= 1'b1;
                    if (r_err_cnt != ERR_MAX)
                        r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    assign o_rot_cnt    = r_rot_cnt;
    assign o_dir        = r_dir;
    assign o_step_pulse = r_step_pulse;
    assign o_err_cnt    = r_err_cnt;
    assign o_err_flag   = r_err_flag;

endmodule
